// File: rtl/pipe_skid_reg_if.sv
// pipe_skid_reg_if
// Handshake bundle around one pipeline register stage.
//   in_valid/in_data/in_ready    : upstream valid/ready channel
//   out_valid/out_data/out_ready : downstream valid/ready channel
//   flush                        : discard everything stored in the stage
//   occupancy/drop_cnt           : status (stored entries, flushed-entry count)
// Modports:
//   slave  - the register stage itself
//   master - the environment driving the stage (upstream + downstream + control)
interface pipe_skid_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
);
    logic              flush;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  drop_cnt;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, occupancy, drop_cnt
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, occupancy, drop_cnt
    );
endinterface

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg
// Inter-stage pipeline register with a one-entry skid buffer. in_ready is a
// pure register output (!skid_valid) yet one transfer per cycle is sustained.
// Flush empties both entries, shows a NOP bubble downstream and adds the number
// of discarded valid entries to a saturating drop counter.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - pipe_skid_reg_if.slave: flush, in_valid/in_data/in_ready,
//          out_valid/out_data/out_ready, occupancy, drop_cnt
module pipe_skid_reg #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CNT_W     = 8
) (
    input  logic          clk,
    input  logic          rst,
    pipe_skid_reg_if.slave bus
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              skid_valid_q, skid_valid_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [CNT_W-1:0]  drop_cnt_q,  drop_cnt_d;

    logic       in_fire;
    logic       out_fire;
    logic [1:0] occupancy;
    logic [1:0] dropped;

    // Saturating add of a 0..2 drop amount onto the counter.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [1:0]       b);
        logic [CNT_W+1:0] sum;
        logic [CNT_W+1:0] max;
        sum = {2'b00, a} + {{CNT_W{1'b0}}, b};
        max = {2'b00, {CNT_W{1'b1}}};
        if (sum > max) begin
            return {CNT_W{1'b1}};
        end
        return sum[CNT_W-1:0];
    endfunction

    assign in_fire   = bus.in_valid & ~skid_valid_q;
    assign out_fire  = out_valid_q & bus.out_ready;
    assign occupancy = {1'b0, out_valid_q} + {1'b0, skid_valid_q};
    // An entry leaving downstream on the flush edge is a completed transfer,
    // not a drop.
    assign dropped   = occupancy - {1'b0, out_fire};

    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        drop_cnt_d   = drop_cnt_q;

        if (bus.flush) begin
            out_valid_d  = 1'b0;
            out_data_d   = NOP_VALUE;
            skid_valid_d = 1'b0;
            drop_cnt_d   = sat_add(drop_cnt_q, dropped);
        end else if (!out_valid_q || out_fire) begin
            // Main register frees up: skid has priority to keep FIFO order.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (in_fire) begin
                out_valid_d = 1'b1;
                out_data_d  = bus.in_data;
            end else begin
                out_valid_d = 1'b0;
                out_data_d  = NOP_VALUE;
            end
        end else if (in_fire) begin
            // Main stalled: park the accepted word; in_ready drops next cycle.
            skid_valid_d = 1'b1;
            skid_data_d  = bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= NOP_VALUE;
            skid_valid_q <= 1'b0;
            skid_data_q  <= NOP_VALUE;
            drop_cnt_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.in_ready  = ~skid_valid_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.occupancy = occupancy;
    assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg
// Directed bench for pipe_skid_reg: reset, streaming, backpressure,
// simultaneous drain/fill, flush and drop counter saturation (CNT_W=2).
module tb_pipe_skid_reg;

    localparam int         DATA_W = 8;
    localparam int         CNT_W  = 2;
    localparam logic [7:0] NOP    = 8'hA5;

    logic clk;
    logic rst;

    pipe_skid_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    pipe_skid_reg #(
        .DATA_W    (DATA_W),
        .NOP_VALUE (NOP),
        .CNT_W     (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input logic ov, input logic [7:0] od,
                             input logic ir, input logic [1:0] occ);
        n_checks++;
        assert (bus.out_valid === ov) else begin
            n_fail++;
            $error("FAIL %s out_valid: observed %b expected %b", tag, bus.out_valid, ov);
        end
        n_checks++;
        assert (bus.out_data === od) else begin
            n_fail++;
            $error("FAIL %s out_data: observed %h expected %h", tag, bus.out_data, od);
        end
        n_checks++;
        assert (bus.in_ready === ir) else begin
            n_fail++;
            $error("FAIL %s in_ready: observed %b expected %b", tag, bus.in_ready, ir);
        end
        n_checks++;
        assert (bus.occupancy === occ) else begin
            n_fail++;
            $error("FAIL %s occupancy: observed %0d expected %0d", tag, bus.occupancy, occ);
        end
    endtask

    task automatic chk_drop(input string tag, input logic [1:0] exp);
        n_checks++;
        assert (bus.drop_cnt === exp) else begin
            n_fail++;
            $error("FAIL %s drop_cnt: observed %0d expected %0d", tag, bus.drop_cnt, exp);
        end
    endtask

    initial begin
        rst           = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // Reset state
        #12;
        chk_state("reset", 1'b0, NOP, 1'b1, 2'd0);
        chk_drop("reset", 2'd0);
        rst = 1'b1;
        tick();
        chk_state("idle", 1'b0, NOP, 1'b1, 2'd0);

        // Streaming
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h11;
        tick();
        chk_state("stream11", 1'b1, 8'h11, 1'b1, 2'd1);
        bus.in_data = 8'h22;
        tick();
        chk_state("stream22", 1'b1, 8'h22, 1'b1, 2'd1);
        bus.in_data = 8'h33;
        tick();
        chk_state("stream33", 1'b1, 8'h33, 1'b1, 2'd1);
        bus.in_valid = 1'b0;
        tick();
        chk_state("stream_empty", 1'b0, NOP, 1'b1, 2'd0);

        // Backpressure: A, B, C
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h0A;
        tick();
        chk_state("bp_A", 1'b1, 8'h0A, 1'b1, 2'd1);
        bus.in_data = 8'h0B;
        tick();
        chk_state("bp_B_skid", 1'b1, 8'h0A, 1'b0, 2'd2);
        bus.in_data = 8'h0C;
        tick();
        chk_state("bp_C_held", 1'b1, 8'h0A, 1'b0, 2'd2);
        bus.out_ready = 1'b1;
        tick();
        chk_state("bp_out_B", 1'b1, 8'h0B, 1'b1, 2'd1);
        tick();
        chk_state("bp_out_C", 1'b1, 8'h0C, 1'b1, 2'd1);
        bus.in_valid = 1'b0;
        tick();
        chk_state("bp_empty", 1'b0, NOP, 1'b1, 2'd0);

        // Simultaneous drain and fill
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h1A;
        tick();
        chk_state("df_A", 1'b1, 8'h1A, 1'b1, 2'd1);
        bus.out_ready = 1'b1;
        bus.in_data   = 8'h0D;
        tick();
        chk_state("df_D", 1'b1, 8'h0D, 1'b1, 2'd1);

        // Flush at occupancy 2 with E offered
        bus.out_ready = 1'b0;
        bus.in_data   = 8'h31;
        tick();
        chk_state("fl_fill", 1'b1, 8'h0D, 1'b0, 2'd2);
        bus.flush   = 1'b1;
        bus.in_data = 8'hE0;
        tick();
        chk_state("fl_after", 1'b0, NOP, 1'b1, 2'd0);
        chk_drop("fl_after", 2'd2);
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        chk_state("fl_no_E", 1'b0, NOP, 1'b1, 2'd0);

        // Saturation: two further flushes at occupancy 2
        for (int k = 0; k < 2; k++) begin
            bus.out_ready = 1'b0;
            bus.in_valid  = 1'b1;
            bus.in_data   = 8'h41;
            tick();
            bus.in_data = 8'h42;
            tick();
            chk_state("sat_fill", 1'b1, 8'h41, 1'b0, 2'd2);
            bus.in_valid = 1'b0;
            bus.flush    = 1'b1;
            tick();
            bus.flush = 1'b0;
            chk_state("sat_after", 1'b0, NOP, 1'b1, 2'd0);
            chk_drop("sat_cnt", 2'd3);
        end

        // Asynchronous reset mid-operation
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h51;
        tick();
        bus.in_data = 8'h52;
        tick();
        chk_state("rst_fill", 1'b1, 8'h51, 1'b0, 2'd2);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_state("rst_async", 1'b0, NOP, 1'b1, 2'd0);
        chk_drop("rst_async", 2'd0);
        #2;
        rst = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h61;
        tick();
        chk_state("rst_first_accept", 1'b1, 8'h61, 1'b1, 2'd1);
        chk_drop("rst_first_accept", 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
